// File: rtl/ni_flit_injector_pkg.sv
// Channel field widths, flit layout and injector FSM encoding shared by the
// network-interface injector and its flit queue.
package ni_flit_injector_pkg;

  localparam int PKTID_SIZE      = 8;
  localparam int FLITNUM_SIZE    = 2;
  localparam int COORDINATE_SIZE = 6;
  localparam int FLITTYPE_SIZE   = 2;
  localparam int DATA_SIZE       = 128;
  localparam int CHANNEL_SIZE    = PKTID_SIZE + FLITNUM_SIZE + 2 * COORDINATE_SIZE
                                 + FLITTYPE_SIZE + DATA_SIZE;

  typedef struct packed {
    logic [PKTID_SIZE-1:0]      pkt_id;
    logic [FLITNUM_SIZE-1:0]    flit_num;
    logic [COORDINATE_SIZE-1:0] src;
    logic [COORDINATE_SIZE-1:0] dst;
    logic [FLITTYPE_SIZE-1:0]   ftype;
    logic [DATA_SIZE-1:0]       data;
  } flit_t;

  typedef enum logic {
    INJ_IDLE = 1'b0,
    INJ_LOAD = 1'b1
  } inj_state_e;

endpackage

// File: rtl/ni_flit_injector_fifo.sv
// Synchronous flit queue: head is visible the cycle after the first write; pushes
// are dropped when full and pops when empty, so callers gate with the flags.
module ni_flit_injector_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ni_flit_injector.sv
// Builds router flits from core header+payload beats, queues them and injects via
// injectReq/injectGrant; raises wakeUp while the router is gated and flags starvation.
module ni_flit_injector
  import ni_flit_injector_pkg::*;
#(
  parameter logic [COORDINATE_SIZE-1:0] MY_COORD      = 6'o00,
  parameter int                         FIFO_DEPTH    = 4,
  parameter int                         STARVE_THRESH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pktValid,
  output logic                       pktReady,
  input  logic [COORDINATE_SIZE-1:0] pktDst,
  input  logic [FLITTYPE_SIZE-1:0]   pktType,
  input  logic [FLITNUM_SIZE-1:0]    pktLen,
  input  logic                       dataValid,
  output logic                       dataReady,
  input  logic [DATA_SIZE-1:0]       dataIn,
  output logic                       injectReq,
  input  logic                       injectGrant,
  output logic [CHANNEL_SIZE-1:0]    outFlit,
  input  logic                       routerPG,
  output logic                       wakeUp,
  output logic                       starved
);

  localparam int SW = $clog2(STARVE_THRESH + 1);

  inj_state_e                 r_state, w_state_nxt;
  logic [COORDINATE_SIZE-1:0] r_dst;
  logic [FLITTYPE_SIZE-1:0]   r_type;
  logic [FLITNUM_SIZE-1:0]    r_len;
  logic [FLITNUM_SIZE-1:0]    r_flit_cnt;
  logic [PKTID_SIZE-1:0]      r_pkt_id;
  logic [SW-1:0]              r_starve_cnt, w_starve_nxt;
  logic                       r_starved;
  logic                       r_wake;
  logic                       w_full, w_empty, w_push, w_pop, w_hdr_acc, w_last;
  flit_t                      w_wr_flit, w_head;

  // pktReady is qualified by reset so every output reads 0 while reset is held
  assign pktReady  = (r_state == INJ_IDLE) && reset;
  assign dataReady = (r_state == INJ_LOAD) && !w_full;
  assign w_hdr_acc = pktValid && pktReady;
  assign w_push    = dataValid && dataReady;
  assign w_last    = w_push && (r_flit_cnt == r_len);
  assign injectReq = !w_empty && !routerPG;
  assign outFlit   = injectReq ? w_head : '0;
  assign w_pop     = injectReq && injectGrant;
  assign wakeUp    = r_wake;
  assign starved   = r_starved;

  assign w_wr_flit = '{pkt_id: r_pkt_id, flit_num: r_flit_cnt, src: MY_COORD,
                       dst: r_dst, ftype: r_type, data: dataIn};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INJ_IDLE: if (w_hdr_acc) w_state_nxt = INJ_LOAD;
      INJ_LOAD: if (w_last)    w_state_nxt = INJ_IDLE;
      default:                 w_state_nxt = INJ_IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = '0;
    if (injectReq && !injectGrant)
      w_starve_nxt = (r_starve_cnt == SW'(STARVE_THRESH)) ? r_starve_cnt
                                                          : r_starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= INJ_IDLE;
      r_dst        <= '0;
      r_type       <= '0;
      r_len        <= '0;
      r_flit_cnt   <= '0;
      r_pkt_id     <= '0;
      r_starve_cnt <= '0;
      r_starved    <= 1'b0;
      r_wake       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_starved    <= (w_starve_nxt == SW'(STARVE_THRESH));
      r_wake       <= !w_empty && routerPG;
      if (w_hdr_acc) begin
        r_dst      <= pktDst;
        r_type     <= pktType;
        r_len      <= pktLen;
        r_flit_cnt <= '0;
      end else if (w_push) begin
        r_flit_cnt <= r_flit_cnt + FLITNUM_SIZE'(1);
      end
      if (w_last) r_pkt_id <= r_pkt_id + PKTID_SIZE'(1);
    end
  end

  ni_flit_injector_fifo #(
    .W     (CHANNEL_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_wr_flit),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed and randomized checks of ni_flit_injector against a queue-based packet model.
module tb_ni_flit_injector;
  import ni_flit_injector_pkg::*;

  localparam int DEPTH  = 4;
  localparam int THRESH = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       pktValid, pktReady;
  logic [COORDINATE_SIZE-1:0] pktDst;
  logic [FLITTYPE_SIZE-1:0]   pktType;
  logic [FLITNUM_SIZE-1:0]    pktLen;
  logic                       dataValid, dataReady;
  logic [DATA_SIZE-1:0]       dataIn;
  logic                       injectReq, injectGrant;
  logic [CHANNEL_SIZE-1:0]    outFlit;
  logic                       routerPG, wakeUp, starved;

  int checks = 0;
  int errors = 0;

  // reference model: queued flits plus packet-assembly context
  flit_t m_q[$];
  bit    m_busy;
  int    m_pktid, m_fcnt, m_len, m_denied;
  logic [COORDINATE_SIZE-1:0] m_dst;
  logic [FLITTYPE_SIZE-1:0]   m_type;
  bit    m_wake;

  ni_flit_injector #(.MY_COORD(6'o00), .FIFO_DEPTH(DEPTH), .STARVE_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .pktValid(pktValid), .pktReady(pktReady),
    .pktDst(pktDst), .pktType(pktType), .pktLen(pktLen), .dataValid(dataValid),
    .dataReady(dataReady), .dataIn(dataIn), .injectReq(injectReq),
    .injectGrant(injectGrant), .outFlit(outFlit), .routerPG(routerPG),
    .wakeUp(wakeUp), .starved(starved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CHANNEL_SIZE-1:0] obs,
                     input logic [CHANNEL_SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_busy = 0; m_pktid = 0; m_fcnt = 0; m_len = 0; m_denied = 0; m_wake = 0;
    m_dst = '0; m_type = '0;
  endtask

  // One clock: compare every output with the model mid-cycle, then advance the model.
  task automatic cycle();
    flit_t ef, nf;
    bit    req_e, pop, beat, hdr;
    int    sz;
    @(negedge clk);
    sz    = m_q.size();
    req_e = (sz > 0) && !routerPG;
    ef    = req_e ? m_q[0] : '0;
    chk("pktReady",  pktReady,  !m_busy);
    chk("dataReady", dataReady, m_busy && (sz < DEPTH));
    chk("injectReq", injectReq, req_e);
    chk("outFlit",   outFlit,   ef);
    chk("wakeUp",    wakeUp,    m_wake);
    chk("starved",   starved,   m_denied == THRESH);
    pop  = req_e && injectGrant;
    beat = m_busy && dataValid && (sz < DEPTH);
    hdr  = !m_busy && pktValid;
    @(posedge clk);
    m_wake   = (sz > 0) && routerPG;
    m_denied = (req_e && !injectGrant) ? ((m_denied < THRESH) ? m_denied + 1 : THRESH) : 0;
    if (pop) void'(m_q.pop_front());
    if (beat) begin
      nf = '{pkt_id: m_pktid[7:0], flit_num: m_fcnt[1:0], src: 6'o00,
             dst: m_dst, ftype: m_type, data: dataIn};
      m_q.push_back(nf);
      if (m_fcnt == m_len) begin
        m_pktid = (m_pktid + 1) % 256;
        m_busy  = 0;
      end else m_fcnt++;
    end
    if (hdr) begin
      m_busy = 1; m_fcnt = 0; m_len = int'(pktLen); m_dst = pktDst; m_type = pktType;
    end
    #1;
  endtask

  task automatic send_hdr(input logic [5:0] d, input logic [1:0] t, input logic [1:0] l);
    pktValid = 1; pktDst = d; pktType = t; pktLen = l;
    cycle();
    pktValid = 0;
  endtask

  task automatic send_beat(input logic [DATA_SIZE-1:0] d);
    dataValid = 1; dataIn = d;
    cycle();
    dataValid = 0;
  endtask

  initial begin
    logic [CHANNEL_SIZE-1:0] exp1;
    int gpct;
    reset = 0; pktValid = 0; pktDst = '0; pktType = '0; pktLen = '0;
    dataValid = 0; dataIn = '0; injectGrant = 0; routerPG = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pktReady", pktReady, 0);
    chk("rst_injectReq", injectReq, 0);
    chk("rst_outFlit", outFlit, 0);
    reset = 1;
    cycle();

    // single-flit packet with grant held high
    injectGrant = 1;
    send_hdr(6'o12, 2'd0, 2'd0);
    send_beat(128'd4);
    exp1 = {8'd0, 2'd0, 6'o00, 6'o12, 2'd0, 128'd4};
    chk("s1_req", injectReq, 1);
    chk("s1_flit", outFlit, exp1);
    cycle();
    chk("s1_popped", injectReq, 0);

    // four-flit packet, grant denied then given
    injectGrant = 0;
    send_hdr(6'o33, 2'd1, 2'd3);
    for (int i = 5; i <= 8; i++) send_beat(DATA_SIZE'(i));
    repeat (3) cycle();
    injectGrant = 1;
    repeat (5) cycle();

    // fill the queue, blocked fifth beat, single grant frees one slot
    injectGrant = 0;
    send_hdr(6'o21, 2'd2, 2'd3);
    for (int i = 0; i < 4; i++) send_beat(DATA_SIZE'(100 + i));
    send_hdr(6'o22, 2'd3, 2'd0);
    chk("s3_full_dready", dataReady, 0);
    dataValid = 1; dataIn = 128'd200;
    repeat (2) cycle();
    injectGrant = 1;
    cycle();
    injectGrant = 0;
    chk("s3_freed_dready", dataReady, 1);
    cycle();
    dataValid = 0;
    injectGrant = 1;
    repeat (6) cycle();

    // power gating with one queued flit
    routerPG = 1;
    send_hdr(6'o07, 2'd1, 2'd0);
    send_beat(128'hABCD);
    chk("s4_req_gated", injectReq, 0);
    chk("s4_flit_gated", outFlit, 0);
    cycle();
    chk("s4_wake", wakeUp, 1);
    routerPG = 0;
    #1;
    chk("s4_req_ungated", injectReq, 1);
    cycle();
    chk("s4_wake_fall", wakeUp, 0);

    // starvation: 20 denied cycles then one grant
    injectGrant = 0;
    send_hdr(6'o44, 2'd0, 2'd0);
    send_beat(128'd77);
    for (int i = 1; i <= 20; i++) begin
      cycle();
      chk("s5_starved", starved, i >= THRESH);
    end
    injectGrant = 1;
    cycle();
    chk("s5_cleared", starved, 0);

    // 257 single-flit packets force the packet-id wrap
    for (int i = 0; i < 257; i++) begin
      send_hdr(6'($urandom), 2'($urandom), 2'd0);
      send_beat({$urandom, $urandom, $urandom, $urandom});
    end
    repeat (2) cycle();

    // asynchronous reset in the middle of a packet
    injectGrant = 0;
    send_hdr(6'o55, 2'd2, 2'd3);
    send_beat(128'd1);
    send_beat(128'd2);
    #2 reset = 0;
    #1;
    chk("s6_pktReady", pktReady, 0);
    chk("s6_dataReady", dataReady, 0);
    chk("s6_injectReq", injectReq, 0);
    chk("s6_outFlit", outFlit, 0);
    chk("s6_wakeUp", wakeUp, 0);
    chk("s6_starved", starved, 0);
    m_reset();
    @(negedge clk);
    reset = 1;
    #1;
    chk("s6_idle", pktReady, 1);
    repeat (2) cycle();

    // randomized traffic in segments of differing grant probability
    for (int seg = 0; seg < 6; seg++) begin
      gpct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 500; c++) begin
        pktValid    = ($urandom_range(0, 1) == 1);
        pktDst      = 6'($urandom);
        pktType     = 2'($urandom);
        pktLen      = 2'($urandom);
        dataValid   = ($urandom_range(0, 3) != 0);
        dataIn      = {$urandom, $urandom, $urandom, $urandom};
        injectGrant = ($urandom_range(0, 99) < gpct);
        routerPG    = ($urandom_range(0, 7) == 0);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ni_flit_injector.md
Name: ni_flit_injector

Overview:
Local-node network interface transmitter that feeds the router's local injection port. It accepts packets from the core as a header handshake followed by a data beat per flit. It builds complete flits in the router's channel format {PKT_ID, FLIT_NUM, SRC, DST, TYPE, DATA}, queues them, and drives the router's injectReq/injectGrant handshake. It also raises a wake-up request when the local router is power-gated and counts injection starvation.

Parameters:
MY_COORD, 6'o00, this node's coordinate; placed in the SRC field of every flit.
FIFO_DEPTH, 4, flit queue depth in entries; must be a power of 2 and at least 2.
STARVE_THRESH, 16, consecutive denied-request cycles before starved asserts.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
pktValid  input  1  core presents a packet header
pktReady  output  1  header accepted when pktValid && pktReady
pktDst  input  `COORDINATE_SIZE  destination coordinate
pktType  input  `FLITTYPE_SIZE  flit type copied to every flit
pktLen  input  `FLITNUM_SIZE  number of flits minus 1 (0..3)
dataValid  input  1  core presents one flit payload
dataReady  output  1  payload accepted when dataValid && dataReady
dataIn  input  `DATA_SIZE  payload
injectReq  output  1  to router injectReq
injectGrant  input  1  from router injectGrant
outFlit  output  `CHANNEL_SIZE  to router inPortLocal
routerPG  input  1  local router currently power-gated
wakeUp  output  1  wake-up request to the local router
starved  output  1  injection starvation flag

Behaviour:
- Reset (reset==0, asynchronous): FSM=IDLE, FIFO empty, pktID counter=0, flit counter=0, starvation counter=0. All outputs 0, including outFlit.
- FSM states:
  - IDLE: pktReady=1, dataReady=0. On header accept, latch dst/type/len, clear flit counter, go to LOAD.
  - LOAD: pktReady=0, dataReady=!full. Each accepted beat writes {pktID, flitCnt, MY_COORD, dst, type, dataIn} into the FIFO and increments flitCnt. On the beat where flitCnt==len: pktID increments (8-bit wrap 255->0) and the FSM returns to IDLE. That makes pktReady high the next cycle, so back-to-back packets cost one cycle per header.
- FIFO:
  - A write occurs only when !full, so no overflow is possible.
  - When full, a simultaneous pop does not enable a write in the same cycle; dataReady is computed from the registered full flag.
  - When not full and not empty, push and pop in the same cycle are both performed; occupancy is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Injection handshake:
  - injectReq = !empty && !routerPG, combinational from registered state.
  - outFlit = FIFO head when injectReq==1, else all zeros.
  - The head is popped at the clock edge where injectReq && injectGrant. The next flit is presented the following cycle, so sustained throughput is 1 flit/cycle.
  - injectGrant while injectReq==0 is ignored.
  - A head flit is never dropped or reordered; a denied request holds outFlit stable.
- Power gating:
  - wakeUp registered, set when !empty && routerPG, cleared when routerPG==0 or the FIFO is empty.
  - Rises 1 cycle after the condition; falls 1 cycle after routerPG deasserts.
  - While routerPG==1, injectReq stays 0.
- Starvation:
  - Counter increments when injectReq && !injectGrant, saturating at STARVE_THRESH.
  - Cleared on any grant or when injectReq==0.
  - starved = (counter==STARVE_THRESH), registered.
- Reset mid-packet: partially loaded flits remain in the FIFO model but are discarded by the pointer reset. The core must restart the packet.

Decomposition:
- Channel field macros (PKT_ID, FLIT_NUM, SRC, DST, TYPE, DATA ranges and sizes) come from globalVariable.v.
- Add INJ_IDLE/INJ_LOAD state encodings there as `define constants.
- One natural sub-module: inj_flit_fifo, a parameterised synchronous FIFO with full/empty, push/pop and head output.

Test Plan:
1. Reset release, then pkt dst=6'o12 type=0 len=0 data=128'd4, grant held 1 → injectReq 1 cycle after beat; outFlit={8'd0,2'd0,6'o00,6'o12,2'd0,128'd4}; popped; pktID next=1.
2. 4-flit packet len=3, data 5..8, injectGrant=0 for 3 cycles then 1 → outFlit stable while denied; flits emerge with FLIT_NUM 0,1,2,3 in order, same PKT_ID.
3. Fill FIFO (FIFO_DEPTH=4) with grant=0 → dataReady drops after 4th beat; a 5th beat is not accepted; one grant frees one entry and dataReady returns the next cycle.
4. routerPG=1 with 1 queued flit → injectReq=0, outFlit=0, wakeUp=1 next cycle. Deassert routerPG → wakeUp=0 next cycle, injectReq=1 immediately.
5. Grant held 0 for 20 cycles with a pending flit → starved=1 after 16 denied cycles; a single grant → starved=0 next cycle.
6. Send 257 single-flit packets → PKT_ID wraps 255→0; reset asserted mid-packet (after 2 of 4 beats) → all outputs 0 asynchronously, FSM back in IDLE.
